// File: rtl/clk_lock_rst_seq_if.sv
// rtl/clk_lock_rst_seq_if.sv - lock/switch inputs and sequenced reset outputs of clk_lock_rst_seq
interface clk_lock_rst_seq_if #(
  parameter int LOSS_CNT_W = 8
) ();
  logic                  locked;
  logic                  SW;
  logic                  rst_core;
  logic                  rst_periph;
  logic                  ready;
  logic [LOSS_CNT_W-1:0] lock_loss_cnt;
  logic [1:0]            state_o;

  modport master (
    output locked,
    output SW,
    input  rst_core,
    input  rst_periph,
    input  ready,
    input  lock_loss_cnt,
    input  state_o
  );

  modport slave (
    input  locked,
    input  SW,
    output rst_core,
    output rst_periph,
    output ready,
    output lock_loss_cnt,
    output state_o
  );
endinterface

// File: rtl/clk_lock_rst_seq.sv
// rtl/clk_lock_rst_seq.sv - ordered core/peripheral reset release after MMCM lock, with SW debounce
module clk_lock_rst_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_HOLD   = 1024,
  parameter int STAGE_GAP   = 16,
  parameter int DEB_CYCLES  = 65536,
  parameter int LOSS_CNT_W  = 8
) (
  input logic               CLK,
  input logic               RST,
  clk_lock_rst_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_WAIT = 2'b00,
    S_HOLD = 2'b01,
    S_CORE = 2'b10,
    S_RUN  = 2'b11
  } state_t;

  localparam int CNT_MAX = (LOCK_HOLD > STAGE_GAP) ? LOCK_HOLD : STAGE_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int DEB_W   = $clog2(DEB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LOCK_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_lock_sync;
  logic [SYNC_STAGES-1:0] r_sw_sync;
  logic                   w_locked_s;
  logic                   w_sw_s;
  logic [DEB_W-1:0]       r_deb_cnt;
  logic                   r_sw_deb;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_abort;
  logic                   w_loss_inc;
  logic                   w_rst_core_nxt;
  logic                   w_rst_periph_nxt;
  logic                   w_ready_nxt;
  logic                   r_rst_core;
  logic                   r_rst_periph;
  logic                   r_ready;
  logic [LOSS_CNT_W-1:0]  r_lock_loss_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_lock_sync <= '0;
      r_sw_sync   <= '0;
    end else begin
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], bus.locked};
      r_sw_sync   <= {r_sw_sync[SYNC_STAGES-2:0], bus.SW};
    end
  end

  assign w_locked_s = r_lock_sync[SYNC_STAGES-1];
  assign w_sw_s     = r_sw_sync[SYNC_STAGES-1];

  // Any return to the debounced level restarts the stability window.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_deb_cnt <= '0;
      r_sw_deb  <= 1'b0;
    end else if (w_sw_s == r_sw_deb) begin
      r_deb_cnt <= '0;
    end else if (r_deb_cnt == DEB_LAST) begin
      r_sw_deb  <= w_sw_s;
      r_deb_cnt <= '0;
    end else begin
      r_deb_cnt <= r_deb_cnt + 1'b1;
    end
  end

  assign w_abort = !w_locked_s || r_sw_deb;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_loss_inc  = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (w_locked_s && !r_sw_deb) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (w_abort)                 w_state_nxt = S_WAIT;
        else if (r_cnt == HOLD_LAST) w_state_nxt = S_CORE;
        else                         w_cnt_nxt   = r_cnt + 1'b1;
      end
      S_CORE: begin
        if (w_abort) begin
          w_state_nxt = S_WAIT;
          w_loss_inc  = !w_locked_s;
        end else if (r_cnt == GAP_LAST) begin
          w_state_nxt = S_RUN;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (w_abort) begin
          w_state_nxt = S_WAIT;
          w_loss_inc  = !w_locked_s;
        end
      end
      default: w_state_nxt = S_WAIT;
    endcase
  end

  // Outputs are decoded from the next state so the flops switch with the state.
  always_comb begin
    w_rst_core_nxt   = (w_state_nxt == S_WAIT) || (w_state_nxt == S_HOLD);
    w_rst_periph_nxt = (w_state_nxt != S_RUN);
    w_ready_nxt      = (w_state_nxt == S_RUN);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state         <= S_WAIT;
      r_cnt           <= '0;
      r_rst_core      <= 1'b1;
      r_rst_periph    <= 1'b1;
      r_ready         <= 1'b0;
      r_lock_loss_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_rst_core   <= w_rst_core_nxt;
      r_rst_periph <= w_rst_periph_nxt;
      r_ready      <= w_ready_nxt;
      if (w_loss_inc && (r_lock_loss_cnt != {LOSS_CNT_W{1'b1}}))
        r_lock_loss_cnt <= r_lock_loss_cnt + 1'b1;
    end
  end

  assign bus.rst_core      = r_rst_core;
  assign bus.rst_periph    = r_rst_periph;
  assign bus.ready         = r_ready;
  assign bus.lock_loss_cnt = r_lock_loss_cnt;
  assign bus.state_o       = r_state;

endmodule

// File: tb/tb_clk_lock_rst_seq.sv
// tb/tb_clk_lock_rst_seq.sv - directed vector bench for clk_lock_rst_seq
module tb_clk_lock_rst_seq;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  clk_lock_rst_seq_if #(.LOSS_CNT_W(8)) bus ();

  clk_lock_rst_seq #(
    .SYNC_STAGES(2),
    .LOCK_HOLD  (8),
    .STAGE_GAP  (4),
    .DEB_CYCLES (4),
    .LOSS_CNT_W (8)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int         n;
    logic       locked;
    logic       sw;
    logic       core;
    logic       periph;
    logic       ready;
    logic [1:0] st;
    logic [7:0] loss;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic l, input logic s, input logic c,
                     input logic p, input logic r, input logic [1:0] st,
                     input logic [7:0] loss);
    vec_t v;
    v.n = n; v.locked = l; v.sw = s; v.core = c; v.periph = p;
    v.ready = r; v.st = st; v.loss = loss;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic c, input logic p,
                            input logic r, input logic [1:0] st, input logic [7:0] loss);
    check({name, ".rst_core"},   32'(bus.rst_core),      32'(c));
    check({name, ".rst_periph"}, 32'(bus.rst_periph),    32'(p));
    check({name, ".ready"},      32'(bus.ready),         32'(r));
    check({name, ".state"},      32'(bus.state_o),       32'(st));
    check({name, ".loss"},       32'(bus.lock_loss_cnt), 32'(loss));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    check("periph_implies_core", 32'(!bus.rst_periph && bus.rst_core), 32'(0));
  endtask

  initial begin
    int exp_loss;
    checks     = 0;
    errors     = 0;
    RST        = 1'b1;
    bus.locked = 1'b1;
    bus.SW     = 1'b0;

    // release sequence
    add(2, 1, 0, 1, 1, 0, 2'd0, 8'd0);
    add(1, 1, 0, 1, 1, 0, 2'd1, 8'd0);
    add(7, 1, 0, 1, 1, 0, 2'd1, 8'd0);
    add(1, 1, 0, 0, 1, 0, 2'd2, 8'd0);
    add(3, 1, 0, 0, 1, 0, 2'd2, 8'd0);
    add(1, 1, 0, 0, 0, 1, 2'd3, 8'd0);
    // lock loss in S_RUN, then relock up to edge 6 of S_HOLD
    add(2, 0, 0, 0, 0, 1, 2'd3, 8'd0);
    add(1, 0, 0, 1, 1, 0, 2'd0, 8'd1);
    add(2, 1, 0, 1, 1, 0, 2'd0, 8'd1);
    add(1, 1, 0, 1, 1, 0, 2'd1, 8'd1);
    add(3, 1, 0, 1, 1, 0, 2'd1, 8'd1);
    // 3-cycle lock drop during S_HOLD: not counted, full hold restarts
    add(2, 0, 0, 1, 1, 0, 2'd1, 8'd1);
    add(1, 0, 0, 1, 1, 0, 2'd0, 8'd1);
    add(2, 1, 0, 1, 1, 0, 2'd0, 8'd1);
    add(1, 1, 0, 1, 1, 0, 2'd1, 8'd1);
    add(7, 1, 0, 1, 1, 0, 2'd1, 8'd1);
    add(1, 1, 0, 0, 1, 0, 2'd2, 8'd1);
    add(3, 1, 0, 0, 1, 0, 2'd2, 8'd1);
    add(1, 1, 0, 0, 0, 1, 2'd3, 8'd1);

    repeat (3) tick();
    check_outs("reset", 1, 1, 0, 2'd0, 8'd0);
    RST = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.locked = vecs[i].locked;
      bus.SW     = vecs[i].sw;
      repeat (vecs[i].n) tick();
      check_outs($sformatf("vec%0d", i), vecs[i].core, vecs[i].periph,
                 vecs[i].ready, vecs[i].st, vecs[i].loss);
    end

    // short SW bounces never reach the debounced level
    for (int b = 0; b < 3; b++) begin
      bus.SW = 1'b1;
      repeat (2) tick();
      bus.SW = 1'b0;
      repeat (2) tick();
      check("bounce.state", 32'(bus.state_o), 32'(3));
    end
    repeat (4) tick();
    check_outs("bounce_end", 0, 0, 1, 2'd3, 8'd1);

    // long press: abort 7 edges after SW rises, no loss count
    bus.SW = 1'b1;
    repeat (6) tick();
    check("sw_edge6.state", 32'(bus.state_o), 32'(3));
    tick();
    check_outs("sw_abort", 1, 1, 0, 2'd0, 8'd1);
    repeat (5) tick();
    bus.SW = 1'b0;
    repeat (6) tick();
    check("sw_release_wait.state", 32'(bus.state_o), 32'(0));
    tick();
    check("sw_release_hold.state", 32'(bus.state_o), 32'(1));
    repeat (12) tick();
    check_outs("sw_rerun", 0, 0, 1, 2'd3, 8'd1);

    // counter saturation over 300 lock losses
    exp_loss = 1;
    for (int k = 0; k < 300; k++) begin
      bus.locked = 1'b0;
      repeat (3) tick();
      exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
      check($sformatf("loss%0d.state", k), 32'(bus.state_o), 32'(0));
      check($sformatf("loss%0d.cnt", k), 32'(bus.lock_loss_cnt), 32'(exp_loss));
      bus.locked = 1'b1;
      repeat (15) tick();
      check($sformatf("loss%0d.run", k), 32'(bus.state_o), 32'(3));
    end
    check("loss_saturated", 32'(bus.lock_loss_cnt), 32'(255));

    // asynchronous reset while in S_CORE
    bus.locked = 1'b0;
    repeat (3) tick();
    bus.locked = 1'b1;
    repeat (11) tick();
    check_outs("pre_async", 0, 1, 0, 2'd2, 8'd255);
    #2;
    RST = 1'b1;
    #1;
    check_outs("async_rst", 1, 1, 0, 2'd0, 8'd0);
    repeat (2) tick();
    check_outs("async_rst_hold", 1, 1, 0, 2'd0, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_lock_rst_seq.md
Name: clk_lock_rst_seq

Overview:
- Sits directly downstream of the board clock wizard wrapper, in the CLK domain (the BUFG'd board clock).
- Consumes the MMCM `locked` flag and the user switch SW.
- Produces an ordered, glitch-free pair of synchronous active-high resets (core first, then peripherals), a ready flag and a lock-loss diagnostic counter for all logic downstream of the clock wizard.

Parameters:
- SYNC_STAGES, 2: flop depth of the locked and SW synchronizers (minimum 2).
- LOCK_HOLD, 1024: consecutive cycles locked must stay high before rst_core releases.
- STAGE_GAP, 16: cycles between rst_core release and rst_periph release.
- DEB_CYCLES, 65536: consecutive stable cycles required for the debounced SW to change.
- LOSS_CNT_W, 8: width of lock_loss_cnt.

Ports:
- CLK  in  1  single clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- locked  in  1  MMCM lock flag; asynchronous to CLK.
- SW  in  1  user reset request, active-high; asynchronous and bouncy.
- rst_core  out  1  synchronous active-high reset for core logic.
- rst_periph  out  1  synchronous active-high reset for peripheral logic.
- ready  out  1  high only in S_RUN.
- lock_loss_cnt  out  LOSS_CNT_W  saturating count of lock losses after core release.
- state_o  out  2  current FSM state encoding.

Behaviour:
- RST=1 (asynchronous) forces:
  - state S_WAIT; rst_core=1, rst_periph=1, ready=0.
  - lock_loss_cnt=0; all counters 0; synchronizer flops 0; sw_deb=0.
- locked_s is locked after SYNC_STAGES flops. sw_s is SW after SYNC_STAGES flops.
- Debounce:
  - deb_cnt resets to 0 whenever sw_s equals sw_deb.
  - Otherwise deb_cnt increments each cycle.
  - When deb_cnt reaches DEB_CYCLES-1, sw_deb takes sw_s on the next edge and deb_cnt clears.
- FSM states (state_o encoding):
  - S_WAIT (00): hold both resets. Go to S_HOLD with hold_cnt=0 when locked_s=1 and sw_deb=0.
  - S_HOLD (01): hold_cnt increments each cycle. When hold_cnt=LOCK_HOLD-1, go to S_CORE with cnt=0. S_HOLD therefore lasts exactly LOCK_HOLD cycles.
  - S_CORE (10): rst_core=0, rst_periph=1. After STAGE_GAP cycles, go to S_RUN.
  - S_RUN (11): rst_core=0, rst_periph=0, ready=1.
- Abort conditions, checked in S_HOLD, S_CORE and S_RUN:
  - locked_s=0 or sw_deb=1 sends the FSM to S_WAIT on the next edge.
  - All counters clear.
- Lock-loss counting:
  - lock_loss_cnt increments by 1 only when locked_s=0 causes an exit from S_CORE or S_RUN.
  - Saturates at 2^LOSS_CNT_W-1.
  - A locked_s=0 exit from S_HOLD does not count.
  - A sw_deb exit does not count.
- Simultaneous locked_s=0 and sw_deb=1: one transition to S_WAIT and one increment (locked loss has priority).
- Output flops: rst_core, rst_periph and ready are dedicated flops loaded from next-state decode.
  - They change on the same edge the state changes, with no combinational decode on the outputs.
  - rst_periph=0 implies rst_core=0 on every cycle.
- Latency from release of RST with locked=1 and SW=0 held:
  - locked_s=1 after SYNC_STAGES edges.
  - S_HOLD entered on the next edge.
  - rst_core falls LOCK_HOLD edges after that.
  - rst_periph falls and ready rises STAGE_GAP edges after rst_core falls.
- Reset assertion on lock loss: rst_core=1 and rst_periph=1 at most SYNC_STAGES+1 edges after locked falls.
- Any counter reaching its terminal value while an abort condition is present: the abort wins.

Test Plan:
Bench parameters: SYNC_STAGES=2, LOCK_HOLD=8, STAGE_GAP=4, DEB_CYCLES=4, LOSS_CNT_W=8.
- Release RST at edge 0 with locked=1, SW=0 -> S_HOLD at edge 3, rst_core falls at edge 11, rst_periph falls and ready rises at edge 15, lock_loss_cnt=0.
- locked low for 3 cycles at edge 6 (during S_HOLD) -> back to S_WAIT, hold restarts after relock, rst_core stays 1 until 8 full stable cycles, lock_loss_cnt stays 0.
- In S_RUN, drop locked -> rst_core=rst_periph=1 and ready=0 within 3 edges, lock_loss_cnt=1; raise locked -> full sequence repeats with identical edge spacing.
- SW bounces with 2-cycle pulses -> no state change; SW held high 12 cycles -> S_WAIT 2+4+1 edges after the rising edge, lock_loss_cnt unchanged; re-release begins after the debounced SW falls.
- 300 lock-loss events from S_RUN -> lock_loss_cnt=255, no wrap.
- Assert RST during S_CORE -> all outputs return to reset values asynchronously (before the next CLK edge), lock_loss_cnt=0.
